// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction ROM, ALU and output-port signals between the
// sequencer (master) and its environment (slave: ROM, ALU and output sink).
interface cpu_sequencer_if #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 12
);
    // Instruction ROM (synchronous, data valid the cycle after imem_en)
    logic [PC_W-1:0]    imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_data;

    // External combinational 4-bit ALU
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [1:0]         alu_control;
    logic [3:0]         alu_result;

    // Output port (valid/ready)
    logic [3:0]         out_data;
    logic               out_valid;
    logic               out_ready;

    // Status
    logic               zero;
    logic               halted;

    modport master (
        output imem_addr, imem_en, alu_a, alu_b, alu_control,
               out_data, out_valid, zero, halted,
        input  imem_data, alu_result, out_ready
    );

    modport slave (
        input  imem_addr, imem_en, alu_a, alu_b, alu_control,
               out_data, out_valid, zero, halted,
        output imem_data, alu_result, out_ready
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 4-bit CPU. Fetches
// from a synchronous ROM, drives the external ALU during EXEC, writes results
// back to a 4-entry register file and emits register values on a valid/ready
// port. Every instruction takes FETCH, DECODE and EXEC (3 cycles); OUT adds
// at least one handshake cycle, HALT is terminal until reset.
// Optional: define CPU_SEQ_SINGLE_STEP_EN to add a `step` input; FETCH then
// waits (imem_en=0) until step=1 and issues the fetch in that same cycle.
module cpu_sequencer #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 12
) (
    input  logic clk,
    input  logic rst_n,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic step,
`endif
    cpu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_OUT, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_OR   = 4'h2,
        OP_XOR  = 4'h3,
        OP_NOT  = 4'h4,
        OP_LDI  = 4'h5,
        OP_JMP  = 4'h6,
        OP_JZ   = 4'h7,
        OP_OUT  = 4'h8,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        CTL_ADD = 2'b00,
        CTL_OR  = 2'b01,
        CTL_XOR = 2'b10,
        CTL_NOT = 2'b11
    } alu_ctl_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [3:0]         rf_q [4];
    logic [3:0]         rf_d [4];
    logic               zero_q, zero_d;
    logic [3:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               halted_q, halted_d;

    logic               imem_en_c;
    logic [3:0]         alu_a_c, alu_b_c;
    alu_ctl_t           alu_ctl_c;
    logic               fetch_go;

    // Instruction fields
    logic [3:0] opcode;
    logic [1:0] rd, rs;
    logic [3:0] imm;
    assign opcode = ir_q[11:8];
    assign rd     = ir_q[7:6];
    assign rs     = ir_q[5:4];
    assign imm    = ir_q[3:0];

`ifdef CPU_SEQ_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Next-state, datapath update and ALU/ROM drive for the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned (no latches).
        // NOTE: blocking (=) assignments: this block is combinational logic.
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        rf_d        = rf_q;
        zero_d      = zero_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        imem_en_c   = 1'b0;
        alu_a_c     = '0;
        alu_b_c     = '0;
        alu_ctl_c   = CTL_ADD;

        case (state_q)
            S_FETCH: begin
                if (fetch_go) begin
                    imem_en_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                ir_d    = bus.imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_W'(1);
                case (opcode)
                    OP_ADD, OP_OR, OP_XOR: begin
                        alu_a_c   = rf_q[rd];
                        alu_b_c   = rf_q[rs];
                        alu_ctl_c = (opcode == OP_ADD) ? CTL_ADD :
                                    (opcode == OP_OR)  ? CTL_OR  : CTL_XOR;
                        rf_d[rd]  = bus.alu_result;
                        zero_d    = (bus.alu_result == 4'd0);
                    end
                    OP_NOT: begin
                        alu_a_c   = rf_q[rs];
                        alu_ctl_c = CTL_NOT;
                        rf_d[rd]  = bus.alu_result;
                        zero_d    = (bus.alu_result == 4'd0);
                    end
                    OP_LDI: begin
                        rf_d[rd] = imm;
                        zero_d   = (imm == 4'd0);
                    end
                    OP_JMP: pc_d = PC_W'(imm);
                    OP_JZ: begin
                        if (zero_q) pc_d = PC_W'(imm);
                    end
                    OP_OUT: begin
                        out_data_d  = rf_q[rd];
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        pc_d     = pc_q;
                        state_d  = S_HALT;
                    end
                    default: ; // NOP and unused opcodes
                endcase
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking (<=) for all sequential state so every register
        // samples the pre-edge values.
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Architectural state: pc, IR, register file, zero flag, output port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            ir_q        <= '0;
            // NOTE: the register file is reset on purpose: programs may read
            // R0-R3 before writing them and must see 0.
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            zero_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rf_q        <= rf_d;
            zero_q      <= zero_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    // The reset state is FETCH; keep the ROM enable low while reset is held.
    assign bus.imem_en     = imem_en_c & rst_n;
    assign bus.alu_a       = alu_a_c;
    assign bus.alu_b       = alu_b_c;
    assign bus.alu_control = alu_ctl_c;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.zero        = zero_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer. Provides the ROM
// and ALU, and checks the DUT against an instruction-level model of the CPU.
module tb_cpu_sequencer;

    logic clk;
    logic rst_n;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic step;
`endif

    cpu_sequencer_if #(.PC_W(4), .INSTR_W(12)) bus ();

    cpu_sequencer #(.PC_W(4), .INSTR_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: synchronous ROM and combinational ALU
    logic [11:0] rom [16];

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= rom[bus.imem_addr];
    end

    always_comb begin
        case (bus.alu_control)
            2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
            2'b01:   bus.alu_result = bus.alu_a | bus.alu_b;
            2'b10:   bus.alu_result = bus.alu_a ^ bus.alu_b;
            default: bus.alu_result = ~bus.alu_a;
        endcase
    end

    // Cycle index since reset release and count of issued fetches
    int cyc;
    int fetch_cnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end
    always @(posedge clk) begin
        if (bus.imem_en) fetch_cnt <= fetch_cnt + 1;
    end

    // Instruction-level model state
    logic [3:0] m_r [4];
    logic [3:0] m_pc;
    logic       m_z;
    logic       m_halt;
    logic [3:0] outs [$];
    int         first_valid_cyc;
    int         last_out_cycles;
    int         ready_mode;   // 0: random ready, 1: low for hold_n cycles
    int         hold_n;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Release reset on a falling edge; cycle 0 (first FETCH) starts here.
    task automatic release_reset();
        m_pc   = '0;
        m_z    = 1'b0;
        m_halt = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        outs.delete();
        first_valid_cyc = -1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic full_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        release_reset();
    endtask

    task automatic load(input logic [11:0] p [$]);
        for (int i = 0; i < 16; i++) rom[i] = (i < p.size()) ? p[i] : 12'h000;
    endtask

    // Runs up to n instructions (stops after HALT). Entered and left while
    // the DUT is in FETCH, sampled away from the rising edge.
    task automatic run_instrs(input int n);
        logic [11:0] ins;
        logic [3:0]  op, imm, ea, eb, res, exp_out, next_pc;
        logic [1:0]  ec, rd, rs;
        int          held;
        for (int k = 0; k < n; k++) begin
            if (m_halt) break;
            bus.out_ready = 1'($urandom_range(0, 1)); // ignored while out_valid=0
            check("fetch_en", bus.imem_en, 1);
            check("fetch_addr", bus.imem_addr, m_pc);
            ins = rom[m_pc];
            op  = ins[11:8];
            rd  = ins[7:6];
            rs  = ins[5:4];
            imm = ins[3:0];
            ea = 0; eb = 0; ec = 0; res = 0; exp_out = 0;
            case (op)
                4'h1: begin ea = m_r[rd]; eb = m_r[rs]; ec = 2'd0; res = ea + eb; end
                4'h2: begin ea = m_r[rd]; eb = m_r[rs]; ec = 2'd1; res = ea | eb; end
                4'h3: begin ea = m_r[rd]; eb = m_r[rs]; ec = 2'd2; res = ea ^ eb; end
                4'h4: begin ea = m_r[rs]; ec = 2'd3; res = ~ea; end
                default: ;
            endcase
            @(negedge clk); // DECODE
            check("decode_quiet", {bus.imem_en, bus.alu_a, bus.alu_b, bus.alu_control}, 0);
            @(negedge clk); // EXEC
            check("exec_alu", {bus.alu_a, bus.alu_b, bus.alu_control}, {ea, eb, ec});
            next_pc = m_pc + 4'd1;
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: begin m_r[rd] = res; m_z = (res == 0); end
                4'h5: begin m_r[rd] = imm; m_z = (imm == 0); end
                4'h6: next_pc = imm;
                4'h7: if (m_z) next_pc = imm;
                4'h8: exp_out = m_r[rd];
                4'hF: begin m_halt = 1'b1; next_pc = m_pc; end
                default: ;
            endcase
            m_pc = next_pc;
            @(negedge clk);
            check("zero", bus.zero, m_z);
            check("halted", bus.halted, m_halt);
            if (op == 4'h8) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                held = 0;
                for (int c = 0; c < 32; c++) begin
                    check("out_valid", bus.out_valid, 1);
                    check("out_data", bus.out_data, exp_out);
                    held++;
                    if (ready_mode == 1) bus.out_ready = (c >= hold_n);
                    else bus.out_ready = (c >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (bus.out_ready) break;
                end
                last_out_cycles = held;
                outs.push_back(exp_out);
                check("out_drop", bus.out_valid, 0);
            end else begin
                check("valid_idle", bus.out_valid, 0);
            end
        end
    endtask

    logic [11:0] prog [$];
    int          snap;

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        ready_mode    = 0;
        hold_n        = 0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        step = 1'b1;
`endif
        for (int i = 0; i < 16; i++) rom[i] = 12'h000;

        // Reset state
        #1;
        check("rst_outputs", {bus.imem_en, bus.imem_addr, bus.out_valid, bus.out_data,
                              bus.zero, bus.halted}, 0);
        check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_control}, 0);

        // Program 1: LDI R0,7; LDI R1,9; ADD R0,R1; OUT R0; HALT
        prog = '{12'h507, 12'h549, 12'h110, 12'h800, 12'hF00};
        load(prog);
        release_reset();
        run_instrs(10);
        check("p1_first_valid_cycle", first_valid_cyc, 12);
        check("p1_out_count", outs.size(), 1);
        if (outs.size() == 1) check("p1_out_value", outs[0], 4'h0);
        check("p1_zero", bus.zero, 1);

        // Program 2: LDI R2,A; NOT R3,R2; XOR R3,R2; OUT R3; HALT, ready low 5 cycles
        prog = '{12'h58A, 12'h4E0, 12'h3E0, 12'h8C0, 12'hF00};
        load(prog);
        ready_mode = 1;
        hold_n     = 5;
        full_reset();
        run_instrs(10);
        ready_mode = 0;
        check("p2_out_count", outs.size(), 1);
        if (outs.size() == 1) check("p2_out_value", outs[0], 4'hF);
        check("p2_hold_cycles", last_out_cycles, 6);

        // JZ taken to HALT, then no further fetches
        prog = '{12'h500, 12'h703, 12'h541, 12'hF00};
        load(prog);
        rom[15] = 12'h000;
        full_reset();
        run_instrs(10);
        snap = fetch_cnt;
        repeat (12) @(negedge clk);
        check("halt_no_fetch", fetch_cnt - snap, 0);
        check("halt_sticky", bus.halted, 1);
        check("halt_pc_hold", bus.imem_addr, 3);

        // 16+ NOPs: pc wraps 15 -> 0
        prog = '{};
        load(prog);
        full_reset();
        run_instrs(18);
        check("wrap_addr", bus.imem_addr, 2);

        // Asynchronous reset in the middle of an OUT handshake
        prog = '{12'h507, 12'h549, 12'h110, 12'h800, 12'hF00};
        load(prog);
        full_reset();
        run_instrs(3);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", bus.out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {bus.out_valid, bus.out_data, bus.imem_addr,
                                    bus.zero, bus.halted, bus.imem_en}, 0);
        prog = '{12'h800, 12'h840, 12'h880, 12'h8C0, 12'hF00};
        load(prog);
        release_reset();
        run_instrs(6);
        check("rst_regs_out_count", outs.size(), 4);
        if (outs.size() == 4) check("rst_regs_zero", {outs[0], outs[1], outs[2], outs[3]}, 0);

        // Reset while halted clears halted immediately
        #2 rst_n = 1'b0;
        #1;
        check("rst_clears_halted", bus.halted, 0);

        // Randomized programs against the model
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 16; i++) rom[i] = 12'($urandom);
            full_reset();
            run_instrs(40);
        end

`ifdef CPU_SEQ_SINGLE_STEP_EN
        // Single step: no fetch while step=0, one instruction per pulse
        prog = '{12'h507, 12'h549, 12'h110, 12'hF00};
        load(prog);
        step = 1'b0;
        full_reset();
        snap = fetch_cnt;
        for (int c = 0; c < 8; c++) begin
            check("step_idle_en", bus.imem_en, 0);
            @(negedge clk);
        end
        check("step_idle_cnt", fetch_cnt - snap, 0);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            #1;
            check("step_fetch_en", bus.imem_en, 1);
            check("step_fetch_addr", bus.imem_addr, p);
            @(negedge clk);
            step = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("step_three_fetches", fetch_cnt - snap, 3);
        check("step_pc", bus.imem_addr, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
